// File: rtl/des_seq_ctrl_if.sv
// Handshake and round-control bundle between the DES round sequencer and its
// requester / datapath; master drives requests, slave is the controller.
interface des_seq_ctrl_if;
  logic       in_valid;
  logic       in_decrypt;
  logic       in_ready;
  logic       ld_block;
  logic       rnd_en;
  logic [3:0] rnd_idx;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       last_rnd;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    output in_valid, in_decrypt, out_ready,
    input  in_ready, ld_block, rnd_en, rnd_idx, key_shift, key_dir,
           last_rnd, out_valid, busy
  );

  modport slave (
    input  in_valid, in_decrypt, out_ready,
    output in_ready, ld_block, rnd_en, rnd_idx, key_shift, key_dir,
           last_rnd, out_valid, busy
  );
endinterface

// File: rtl/des_seq_ctrl.sv
// DES round sequencer: accepts a block, steps 16 Feistel rounds with the key
// schedule rotate amounts, then holds the result. Option: DES_SEQ_CTRL_B2B_EN.
module des_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  des_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t     state;
  logic       mode;
  logic       rnd_en_q;
  logic [3:0] rnd_idx_q;
  logic [1:0] key_shift_q;
  logic       last_rnd_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       accept_rdy;
  logic       accept;

  // Rotate schedule; decrypt skips the first rotate since C/D start aligned.
  function automatic logic [1:0] shift_amt(input logic dec, input logic [3:0] idx);
    logic [1:0] amt;
    case (idx)
      4'd0:                 amt = dec ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15:    amt = 2'd1;
      default:              amt = 2'd2;
    endcase
    return amt;
  endfunction

`ifdef DES_SEQ_CTRL_B2B_EN
  assign accept_rdy = (state == IDLE) | ((state == DONE) & bus.out_ready);
`else
  assign accept_rdy = (state == IDLE);
`endif

  assign accept        = bus.in_valid & accept_rdy;
  assign bus.in_ready  = accept_rdy;
  assign bus.ld_block  = accept;
  assign bus.rnd_en    = rnd_en_q;
  assign bus.rnd_idx   = rnd_idx_q;
  assign bus.key_shift = key_shift_q;
  assign bus.key_dir   = mode;
  assign bus.last_rnd  = last_rnd_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= 1'b0;
      rnd_en_q    <= 1'b0;
      rnd_idx_q   <= 4'd0;
      key_shift_q <= 2'd0;
      last_rnd_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      // A retire-and-accept in DONE lands here too, restarting at round 0.
      state       <= ROUND;
      mode        <= bus.in_decrypt;
      rnd_en_q    <= 1'b1;
      rnd_idx_q   <= 4'd0;
      key_shift_q <= shift_amt(bus.in_decrypt, 4'd0);
      last_rnd_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        ROUND: begin
          if (rnd_idx_q == 4'd15) begin
            state       <= DONE;
            rnd_en_q    <= 1'b0;
            rnd_idx_q   <= 4'd0;
            key_shift_q <= 2'd0;
            last_rnd_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            rnd_idx_q   <= rnd_idx_q + 4'd1;
            key_shift_q <= shift_amt(mode, rnd_idx_q + 4'd1);
            last_rnd_q  <= (rnd_idx_q == 4'd14);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rnd_en_q    <= 1'b0;
          rnd_idx_q   <= 4'd0;
          key_shift_q <= 2'd0;
          last_rnd_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
